// File: rtl/mono_mode_ctrl.sv
// mono_mode_ctrl: produces the 2-bit monochrome_switcher code for the colour/luma output mux
// (00 colour, 01 green, 10 amber, 11 B/W).
// Mode requests come from a CPU I/O register at PORT_ADDR (write and readback) and from a PS/2
// set-2 hotkey that steps the pending mode.
//
// Build option: MONO_VSYNC_SYNC_EN
//   defined   - the pending mode becomes active only at the vsync leading edge.
//   undefined - the active mode follows the pending mode one clock later; vga_vsync is unused and
//               mode_pending stays 0.
//
// Ports:
//   clk_vga             pixel clock; all inputs are synchronous to it
//   rst_n               asynchronous active-low reset
//   io_addr/io_wdata    CPU I/O address and write data
//   io_wr/io_rd         one-cycle write and read strobes
//   io_rdata            registered read data {2'b00, pending, mode_pending, hk_en, active}
//   kbd_code/kbd_valid  scancode byte and its one-cycle strobe from the PS/2 receiver
//   vga_vsync           vertical sync from the video timing block
//   monochrome_switcher active mode, driven straight from a register
//   mode_pending        1 while the requested mode differs from the active mode
module mono_mode_ctrl #(
   parameter logic [15:0] PORT_ADDR   = 16'h03DE,
   parameter logic [7:0]  HOTKEY_CODE = 8'h07,
   parameter logic [1:0]  RESET_MODE  = 2'b00,
   parameter logic        VSYNC_POL   = 1'b0
) (
   input  logic        clk_vga,
   input  logic        rst_n,
   input  logic [15:0] io_addr,
   input  logic [7:0]  io_wdata,
   input  logic        io_wr,
   input  logic        io_rd,
   output logic [7:0]  io_rdata,
   input  logic [7:0]  kbd_code,
   input  logic        kbd_valid,
   input  logic        vga_vsync,
   output logic [1:0]  monochrome_switcher,
   output logic        mode_pending
);

   localparam logic [7:0] CODE_EXT = 8'hE0;
   localparam logic [7:0] CODE_BRK = 8'hF0;

   typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} kbd_state_e;

   kbd_state_e state_q;
   logic [1:0] active_q, active_d;
   logic [1:0] pending_q, pending_d;
   logic       hk_en_q, hk_en_d;
   logic       held_q, held_d;
   logic       mode_pending_q, mode_pending_d;
   logic       wr_hit, rd_hit, hk_make, hk_release;

   assign wr_hit     = io_wr && (io_addr == PORT_ADDR);
   assign rd_hit     = io_rd && (io_addr == PORT_ADDR);
   // Only a plain (non-extended) make or break of the hotkey counts.
   assign hk_make    = kbd_valid && (state_q == StIdle) && (kbd_code == HOTKEY_CODE);
   assign hk_release = kbd_valid && (state_q == StBrk) && (kbd_code == HOTKEY_CODE);

   always_comb begin
      pending_d = pending_q;
      hk_en_d   = hk_en_q;
      held_d    = held_q;
      // held suppresses typematic repeats until the break code arrives.
      if (hk_make && hk_en_q && !held_q) begin
         pending_d = pending_q + 2'd1;
         held_d    = 1'b1;
      end else if (hk_release) begin
         held_d = 1'b0;
      end
      // A CPU write overrides a same-cycle hotkey step; held is left as the hotkey set it.
      if (wr_hit) begin
         pending_d = io_wdata[1:0];
         hk_en_d   = io_wdata[2];
      end
   end

`ifdef MONO_VSYNC_SYNC_EN
   logic vsync_q, vsync_qq, apply;

   always_ff @(posedge clk_vga or negedge rst_n) begin
      if (!rst_n) begin
         vsync_q  <= ~VSYNC_POL;
         vsync_qq <= ~VSYNC_POL;
      end else begin
         vsync_q  <= vga_vsync;
         vsync_qq <= vsync_q;
      end
   end

   assign apply = (vsync_q == VSYNC_POL) && (vsync_qq != VSYNC_POL);
   // Old pending value is applied, so a write landing on the apply cycle waits a frame.
   assign active_d       = apply ? pending_q : active_q;
   assign mode_pending_d = (pending_d != active_d);
`else
   logic unused_vsync;

   assign unused_vsync   = vga_vsync;
   assign active_d       = pending_q;
   assign mode_pending_d = 1'b0;
`endif

   always_ff @(posedge clk_vga or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= StIdle;
         active_q       <= RESET_MODE;
         pending_q      <= RESET_MODE;
         hk_en_q        <= 1'b1;
         held_q         <= 1'b0;
         mode_pending_q <= 1'b0;
         io_rdata       <= 8'h00;
      end else begin
         active_q       <= active_d;
         pending_q      <= pending_d;
         hk_en_q        <= hk_en_d;
         held_q         <= held_d;
         mode_pending_q <= mode_pending_d;
         if (rd_hit) begin
            io_rdata <= {2'b00, pending_q, mode_pending_q, hk_en_q, active_q};
         end
         if (kbd_valid) begin
            case (state_q)
               StIdle: begin
                  if (kbd_code == CODE_EXT) begin
                     state_q <= StExt;
                  end else if (kbd_code == CODE_BRK) begin
                     state_q <= StBrk;
                  end
               end
               StExt:   state_q <= (kbd_code == CODE_BRK) ? StExtBrk : StIdle;
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   assign monochrome_switcher = active_q;
   assign mode_pending        = mode_pending_q;

endmodule

// File: tb/tb_mono_mode_ctrl.sv
module tb_mono_mode_ctrl;

   localparam logic [15:0] PORT_ADDR  = 16'h03DE;
   localparam logic [7:0]  HOTKEY     = 8'h07;
   localparam logic [1:0]  RESET_MODE = 2'b00;
   localparam logic        VSYNC_POL  = 1'b0;
   localparam int          FRAME      = 40;
   localparam int          PULSE      = 3;

   logic        clk_vga = 1'b0;
   logic        rst_n;
   logic [15:0] io_addr;
   logic [7:0]  io_wdata;
   logic        io_wr;
   logic        io_rd;
   logic [7:0]  io_rdata;
   logic [7:0]  kbd_code;
   logic        kbd_valid;
   logic        vga_vsync;
   logic [1:0]  monochrome_switcher;
   logic        mode_pending;

   mono_mode_ctrl #(
      .PORT_ADDR  (PORT_ADDR),
      .HOTKEY_CODE(HOTKEY),
      .RESET_MODE (RESET_MODE),
      .VSYNC_POL  (VSYNC_POL)
   ) dut (
      .clk_vga            (clk_vga),
      .rst_n              (rst_n),
      .io_addr            (io_addr),
      .io_wdata           (io_wdata),
      .io_wr              (io_wr),
      .io_rd              (io_rd),
      .io_rdata           (io_rdata),
      .kbd_code           (kbd_code),
      .kbd_valid          (kbd_valid),
      .vga_vsync          (vga_vsync),
      .monochrome_switcher(monochrome_switcher),
      .mode_pending       (mode_pending)
   );

   always #5 clk_vga = ~clk_vga;

   int n_checks = 0;
   int n_fail   = 0;
   int fcnt     = 10;

   // Reference model: register contents plus the prefix bytes seen so far.
   logic [1:0] m_active, m_pending;
   logic       m_hk_en, m_held;
   logic [7:0] m_rdata;
   logic       m_seen_ext, m_seen_brk;
   logic       m_vs_r, m_vs_rr;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic model_mp();
`ifdef MONO_VSYNC_SYNC_EN
      return m_pending != m_active;
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_reset();
      m_active   = RESET_MODE;
      m_pending  = RESET_MODE;
      m_hk_en    = 1'b1;
      m_held     = 1'b0;
      m_rdata    = 8'h00;
      m_seen_ext = 1'b0;
      m_seen_brk = 1'b0;
      m_vs_r     = ~VSYNC_POL;
      m_vs_rr    = ~VSYNC_POL;
   endtask

   // Advance the model by one clock using the inputs currently driven.
   task automatic model_edge();
      logic       wr, rd, make;
      logic [1:0] np;
      logic       nh, nheld;
      wr    = io_wr && (io_addr == PORT_ADDR);
      rd    = io_rd && (io_addr == PORT_ADDR);
      make  = 1'b0;
      np    = m_pending;
      nh    = m_hk_en;
      nheld = m_held;
      if (rd) m_rdata = {2'b00, m_pending, model_mp(), m_hk_en, m_active};
      if (kbd_valid) begin
         if (m_seen_brk) begin
            if (!m_seen_ext && kbd_code == HOTKEY) nheld = 1'b0;
            m_seen_brk = 1'b0;
            m_seen_ext = 1'b0;
         end else if (m_seen_ext) begin
            if (kbd_code == 8'hF0) m_seen_brk = 1'b1;
            else m_seen_ext = 1'b0;
         end else if (kbd_code == 8'hE0) begin
            m_seen_ext = 1'b1;
         end else if (kbd_code == 8'hF0) begin
            m_seen_brk = 1'b1;
         end else if (kbd_code == HOTKEY) begin
            make = 1'b1;
         end
      end
      if (make && m_hk_en && !m_held) begin
         np    = (m_pending == 2'd3) ? 2'd0 : m_pending + 2'd1;
         nheld = 1'b1;
      end
      if (wr) begin
         np = io_wdata[1:0];
         nh = io_wdata[2];
      end
`ifdef MONO_VSYNC_SYNC_EN
      if (m_vs_r == VSYNC_POL && m_vs_rr != VSYNC_POL) m_active = m_pending;
      m_vs_rr = m_vs_r;
      m_vs_r  = vga_vsync;
`else
      m_active = m_pending;
`endif
      m_pending = np;
      m_hk_en   = nh;
      m_held    = nheld;
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".sw"}, {6'b0, monochrome_switcher}, {6'b0, m_active});
      check({tag, ".mp"}, {7'b0, mode_pending}, {7'b0, model_mp()});
      check({tag, ".rd"}, io_rdata, m_rdata);
   endtask

   task automatic cycle(input string tag);
      vga_vsync = (fcnt < PULSE) ? VSYNC_POL : ~VSYNC_POL;
      fcnt      = (fcnt + 1) % FRAME;
      model_edge();
      @(posedge clk_vga);
      #1;
      check_outputs(tag);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle("idle");
   endtask

   task automatic io_write(input logic [7:0] d);
      io_addr = PORT_ADDR; io_wdata = d; io_wr = 1'b1;
      cycle("wr");
      io_wr = 1'b0;
   endtask

   task automatic io_read();
      io_addr = PORT_ADDR; io_rd = 1'b1;
      cycle("rd");
      io_rd = 1'b0;
   endtask

   task automatic key(input logic [7:0] c);
      kbd_code = c; kbd_valid = 1'b1;
      cycle("kbd");
      kbd_valid = 1'b0;
      cycle("kbd_gap");
   endtask

   // Asynchronous reset asserted mid-cycle, checked before any clock edge.
   task automatic mid_reset();
      #3;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_outputs("async_rst");
      @(posedge clk_vga);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; io_addr = 16'h0; io_wdata = 8'h0; io_wr = 1'b0; io_rd = 1'b0;
      kbd_code = 8'h0; kbd_valid = 1'b0; vga_vsync = ~VSYNC_POL;
      model_reset();
      #12;
      check_outputs("reset");
      @(posedge clk_vga);
      #1;
      rst_n = 1'b1;
      io_read();
      check("reset_read", io_rdata, 8'h04);

      // CPU write, then let at least one vsync pass.
      io_write(8'h06);
      idle(3);
      io_read();
      idle(FRAME + 5);
      check("write_applied", {6'b0, monochrome_switcher}, 8'h02);
      io_read();

      // Hotkey stepping with typematic repeats and a break.
      key(HOTKEY); key(HOTKEY); key(HOTKEY); key(8'hF0); key(HOTKEY); key(HOTKEY);
      idle(FRAME + 5);
      io_read();
      check("hotkey_step", {6'b0, monochrome_switcher}, 8'h00);

      // Extended make/break, plain break, then hotkey disabled.
      key(8'hE0); key(HOTKEY); key(8'hF0); key(HOTKEY);
      io_write(8'h02);
      key(HOTKEY);
      idle(FRAME + 5);
      io_read();
      check("hk_disabled", {6'b0, monochrome_switcher}, 8'h02);

      // Same-cycle write and hotkey make: write wins.
      io_write(8'h04);
      io_addr = PORT_ADDR; io_wdata = 8'h07; io_wr = 1'b1;
      kbd_code = HOTKEY; kbd_valid = 1'b1;
      cycle("wr_vs_kbd");
      io_wr = 1'b0; kbd_valid = 1'b0;
      io_read();
      check("write_wins", io_rdata[5:4] == 2'b11 ? 8'h01 : 8'h00, 8'h01);
      key(HOTKEY);
      idle(FRAME + 5);
      io_write(8'h05);
      idle(2);
      mid_reset();
      io_read();

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         int unsigned sel;
         io_wr     = ($urandom_range(15) == 0);
         io_rd     = ($urandom_range(3) == 0);
         io_addr   = ($urandom_range(3) != 0) ? PORT_ADDR : 16'($urandom);
         io_wdata  = 8'($urandom);
         kbd_valid = ($urandom_range(3) == 0);
         sel       = $urandom_range(4);
         kbd_code  = (sel < 2) ? HOTKEY : (sel == 2) ? 8'hE0 : (sel == 3) ? 8'hF0 : 8'($urandom);
         cycle("rand");
         if ($urandom_range(999) == 0) mid_reset();
      end
      io_wr = 1'b0; io_rd = 1'b0; kbd_valid = 1'b0;
      idle(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
